rl_collector: RTL
=================

RL_COLLECTOR -- requirements
Module: rl_collector

Interface
REQ-001 Parameter NUM_PERIODI, default 10, is the sampling period in clocks; legal range 2..255.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a3_a0  input  4  address nibble from the periodic writer.
REQ-005 z7_z0  input  8  data byte from the periodic writer.
REQ-006 clr  input  1  synchronous clear of the valid mask and the sample counter.
REQ-007 rd_addr  input  4  read address, stable while rd_req=1.
REQ-008 rd_req  input  1  read request (four-phase handshake).
REQ-009 rd_ack  output  1  read acknowledge.
REQ-010 rd_data  output  8  stored byte for rd_addr, valid while rd_ack=1.
REQ-011 rd_vld  output  1  valid-mask bit for rd_addr, valid while rd_ack=1.
REQ-012 full  output  1  high when all 16 valid-mask bits are set.
REQ-013 nsamp  output  8  saturating count of samples taken since reset or clr.

Function
REQ-014 A period counter SHALL load NUM_PERIODI-1 and decrement every clock.
REQ-015 At counter value 0, the counter SHALL reload NUM_PERIODI-1 and assert an internal sample strobe for exactly one clock.
REQ-016 With the counter, the first strobe SHALL occur on the NUM_PERIODI-th rising edge after reset deasserts, then every NUM_PERIODI clocks.
REQ-017 On a strobe, mem[a3_a0] SHALL take the value z7_z0, valid-mask bit a3_a0 SHALL be set, and nsamp SHALL increment, saturating at 255.
REQ-018 A strobe to an already-valid address SHALL overwrite the stored byte; the mask bit stays set.
REQ-019 The 16x8 storage SHALL NOT be cleared by reset or clr; only the valid mask marks contents as meaningful.
REQ-020 clr=1 SHALL, on the next edge, zero the valid mask and nsamp and reload the counter with NUM_PERIODI-1.
REQ-021 clr SHALL take priority over a coincident strobe; that strobe is discarded.
REQ-022 full SHALL be a combinational AND of the 16 mask bits.
REQ-023 The read FSM SHALL have two states, R_IDLE and R_ACK.
REQ-024 R_IDLE with rd_req=1 SHALL capture mem[rd_addr] into rd_data and mask[rd_addr] into rd_vld, set rd_ack=1, and go to R_ACK.
REQ-025 R_ACK with rd_req=0 SHALL clear rd_ack and go to R_IDLE; with rd_req=1 it SHALL hold.
REQ-026 rd_data and rd_vld SHALL hold their captured values until the next capture.
REQ-027 A capture coinciding with a strobe to the same address SHALL return the pre-write byte and pre-write mask bit.
REQ-028 A capture coinciding with clr SHALL return the pre-clear mask bit.
REQ-029 Sampling SHALL continue regardless of the read FSM state.

Reset
REQ-030 While reset=1, the following SHALL hold immediately, independent of clock: rd_ack=0, rd_data=0, rd_vld=0, nsamp=0, mask=0 (so full=0), counter=NUM_PERIODI-1, read FSM=R_IDLE.
REQ-031 Reset during R_ACK SHALL abort the handshake; rd_ack falls without waiting for rd_req=0.

Structure
REQ-032 A shared package rl_pkg SHALL hold the read-FSM state enum and the NUM_PERIODI default constant.
REQ-033 The period counter with strobe generation SHALL be a sub-module, rl_period_tick, parameterised by NUM_PERIODI.
REQ-034 The storage, mask, nsamp and read FSM SHALL reside in rl_collector.

Verification
REQ-035 Reset release, a3_a0=5, z7_z0=8'hA7 held -> single strobe at edge 10; then read 5 -> rd_data=8'hA7, rd_vld=1, nsamp=1.
REQ-036 Drive addresses 0..15 with data 8'h10+addr, one per period -> full=1 after the 16th strobe, nsamp=16; every read matches.
REQ-037 Read address 3 with the capture on the strobe edge writing 8'h55 to address 3 (previously 8'h22) -> rd_data=8'h22; next read -> 8'h55.
REQ-038 clr on the strobe edge -> mask=0, nsamp=0; next strobe occurs NUM_PERIODI clocks later.
REQ-039 Assert reset while rd_ack=1 and rd_req=1 -> rd_ack=0 at once; after release, rd_req still 1 -> new ack one edge later.
REQ-040 Run 300 periods -> nsamp saturates at 255 and does not wrap.

Source files
------------

// File: rtl/rl_pkg.sv
// Shared types and constants for the periodic-sample collector.
// Holds the read-handshake state encoding and the default sampling period.
package rl_pkg;

  localparam int NUM_PERIODI_DEF = 10;
  localparam int NUM_ADDR        = 16;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/rl_period_tick.sv
// Free-running period counter producing a one-clock sample strobe every NUM_PERIODI clocks.
// The strobe is high while the counter sits at zero, so the sample lands on the reload edge.
module rl_period_tick
  import rl_pkg::*;
#(
  parameter int NUM_PERIODI = NUM_PERIODI_DEF
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_strobe
);

  localparam logic [7:0] RELOAD = 8'(NUM_PERIODI - 1);

  logic [7:0] r_cnt;
  logic       w_zero;

  assign w_zero = (r_cnt == 8'd0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= RELOAD;
    end else if (i_clr || w_zero) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_strobe = w_zero;

endmodule

// File: rtl/rl_collector.sv
// Samples (address, data) from a periodic writer into a 16x8 store with a valid mask,
// and serves reads through a four-phase req/ack handshake.
module rl_collector
  import rl_pkg::*;
#(
  parameter int NUM_PERIODI = NUM_PERIODI_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] a3_a0,
  input  logic [7:0] z7_z0,
  input  logic       clr,
  input  logic [3:0] rd_addr,
  input  logic       rd_req,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       rd_vld,
  output logic       full,
  output logic [7:0] nsamp
);

  logic [7:0]            r_mem [NUM_ADDR];
  logic [NUM_ADDR-1:0]   r_mask;
  logic [7:0]            r_nsamp;
  logic [7:0]            r_rdData;
  logic                  r_rdVld;
  rd_state_t             r_state;
  rd_state_t             w_nextState;
  logic                  w_capture;
  logic                  w_strobe;
  logic                  w_sample;

  rl_period_tick #(
    .NUM_PERIODI(NUM_PERIODI)
  ) u_tick (
    .i_clock (clock),
    .i_reset (reset),
    .i_clr   (clr),
    .o_strobe(w_strobe)
  );

  // A clear on the same edge as a strobe wins and the sample is dropped.
  assign w_sample = w_strobe & ~clr;

  always_ff @(posedge clock) begin
    if (w_sample) begin
      r_mem[a3_a0] <= z7_z0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mask  <= '0;
      r_nsamp <= 8'd0;
    end else if (clr) begin
      r_mask  <= '0;
      r_nsamp <= 8'd0;
    end else if (w_sample) begin
      r_mask[a3_a0] <= 1'b1;
      if (r_nsamp != 8'hFF) begin
        r_nsamp <= r_nsamp + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (rd_req) begin
          w_capture   = 1'b1;
          w_nextState = R_ACK;
        end
      end
      R_ACK: begin
        if (!rd_req) begin
          w_nextState = R_IDLE;
        end
      end
      default: w_nextState = R_IDLE;
    endcase
  end

  // Capture reads the pre-edge store and mask, so a coincident write or clear is not seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdData <= 8'd0;
      r_rdVld  <= 1'b0;
    end else if (w_capture) begin
      r_rdData <= r_mem[rd_addr];
      r_rdVld  <= r_mask[rd_addr];
    end
  end

  assign rd_ack  = (r_state == R_ACK);
  assign rd_data = r_rdData;
  assign rd_vld  = r_rdVld;
  assign full    = &r_mask;
  assign nsamp   = r_nsamp;

endmodule
